// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous framebuffer RAM between
// the display fetch path (priority) and the host port (bounded wait). Every
// issued read carries an {valid, owner} tag down a pipeline that matches the
// RAM latency, so the returned word is steered back to whoever asked for it.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int              WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT);
    // Tag stage 0 lines up with mem_* being driven; stage STAGES lines up
    // with mem_rdata being valid.
    localparam int              STAGES   = RD_LAT;

    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STAGES:0]   vld_pipe_q;
    logic [STAGES:0]   own_pipe_q;   // 1 = host owns the read
    logic              issue_rd;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              disp_valid_q, host_rvalid_q;
    logic [DATA_W-1:0] disp_data_q, host_rdata_q;

    // Grant: display wins unless the host has been denied MAX_WAIT cycles in a row
    always_comb begin
        disp_ack = !rst && disp_req && !(host_req && (wait_cnt_q == WAIT_SAT));
        host_ack = !rst && host_req && !disp_ack;
        issue_rd = disp_ack || (host_ack && !host_we);
    end

    // Wait counter next state: count consecutive denied host cycles, saturating
    always_comb begin
        wait_cnt_d = '0;
        if (host_req && !host_ack)
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 1'b1;
    end

    // Wait counter register
    always_ff @(posedge clk_50) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    // RAM command register: capture the winner; idle cycles keep addr/wdata
    always_ff @(posedge clk_50) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (disp_ack) begin
            mem_addr_q  <= disp_addr;
            mem_we_q    <= 1'b0;
        end else if (host_ack) begin
            mem_addr_q  <= host_addr;
            mem_we_q    <= host_we;
            mem_wdata_q <= host_wdata;
        end else begin
            mem_we_q    <= 1'b0;
        end
    end

    // Read tag pipeline; reset drops every read still in flight
    always_ff @(posedge clk_50) begin
        if (rst) begin
            vld_pipe_q <= '0;
            own_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], issue_rd};
            own_pipe_q <= {own_pipe_q[STAGES-1:0], host_ack};
        end
    end

    // Return steering: register RAM data into the owner's output only
    always_ff @(posedge clk_50) begin
        if (rst) begin
            disp_valid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            disp_data_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            disp_valid_q  <= vld_pipe_q[STAGES] && !own_pipe_q[STAGES];
            host_rvalid_q <= vld_pipe_q[STAGES] &&  own_pipe_q[STAGES];
            if (vld_pipe_q[STAGES] && !own_pipe_q[STAGES]) disp_data_q  <= mem_rdata;
            if (vld_pipe_q[STAGES] &&  own_pipe_q[STAGES]) host_rdata_q <= mem_rdata;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_valid  = disp_valid_q;
    assign disp_data   = disp_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule
